// File: rtl/rom_frame_serializer.sv
// -----------------------------------------------------------------------------
// rom_frame_serializer
//
// Purpose:
//   Walks the pattern ROM from address 0 up to LAST_ADDR. For each address it
//   captures the ROM word, which the ROM registers one clock after rom_addr.
//   It then shifts the word out on ser_clk/ser_data to the LED driver chain and
//   pulses latch once per word. A single start request produces one full frame,
//   which ends with a one-clock done pulse.
//
// Build option:
//   SERIALIZER_LSB_FIRST_EN  defined   -> bit 0 of each word is shifted first.
//                            undefined -> MSB first (default).
//   Timing, latch and done behave the same in both builds.
//
// Parameters:
//   ADDR_WIDTH  ROM address width
//   DATA_WIDTH  ROM word width, which is also the number of bits shifted per word
//   LAST_ADDR   last address sequenced (frame covers 0..LAST_ADDR)
//   SCLK_DIV    clk cycles per ser_clk half-period (>= 1)
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   start     in   frame request, sampled only while idle
//   rom_addr  out  registered ROM address
//   rom_data  in   registered ROM output (valid 1 clk after rom_addr)
//   ser_clk   out  serial clock (driver samples ser_data on rising edge)
//   ser_data  out  serial data
//   latch     out  1-clk pulse after the last bit of each word
//   busy      out  high whenever a frame is in progress
//   done      out  1-clk pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module rom_frame_serializer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int LAST_ADDR  = 15,
   parameter int SCLK_DIV   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  ser_clk,
   output logic                  ser_data,
   output logic                  latch,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

   // Counter widths are kept at least 1 bit wide so SCLK_DIV=1 still works.
   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);

   state_t                state;
   logic                  fetch_cnt;
   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;

   // The bit that goes out next is always kept at one end of shift_reg.
   // Advancing the register brings the following bit to that end.
`ifdef SERIALIZER_LSB_FIRST_EN
   function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
      return w[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
      return w >> 1;
   endfunction
`else
   function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
      return w[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
      return w << 1;
   endfunction
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rom_addr  <= '0;
         ser_clk   <= 1'b0;
         ser_data  <= 1'b0;
         latch     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fetch_cnt <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         latch <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FETCH;
                  rom_addr  <= '0;
                  fetch_cnt <= 1'b0;
                  busy      <= 1'b1;
               end
            end

            // First cycle: the ROM registers rom_addr.
            // Second cycle: rom_data is valid and is captured on exit.
            FETCH: begin
               if (!fetch_cnt) begin
                  fetch_cnt <= 1'b1;
               end else begin
                  state     <= SHIFT;
                  shift_reg <= rom_data;
                  ser_data  <= lead_bit(rom_data);
                  ser_clk   <= 1'b0;
                  bit_cnt   <= '0;
                  div_cnt   <= '0;
               end
            end

            // Each bit is a low half followed by a high half.
            // Each half lasts SCLK_DIV clocks.
            SHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!ser_clk) begin
                     ser_clk <= 1'b1;
                  end else begin
                     ser_clk <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= LATCH;
                        latch <= 1'b1;
                     end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        shift_reg <= advance(shift_reg);
                        ser_data  <= lead_bit(advance(shift_reg));
                     end
                  end
               end
            end

            // latch is high for exactly this cycle.
            // ser_data keeps the last bit shifted.
            LATCH: begin
               fetch_cnt <= 1'b0;
               if (rom_addr == ADDR_LAST) begin
                  state    <= IDLE;
                  rom_addr <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  state    <= FETCH;
                  rom_addr <= rom_addr + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_rom_frame_serializer
//
// Two serializer instances run from one clock:
//   u_a  default parameters (16 words, SCLK_DIV=2)
//   u_b  SCLK_DIV=1, LAST_ADDR=3
// Each instance has a registered ROM model.
// Negedge monitors collect the serial bits, latch/done/busy counts and the
// ser_clk rise spacing. The main sequence compares these against values
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_rom_frame_serializer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- instance A: default parameters ----------------
   logic       a_start;
   logic [3:0] a_rom_addr;
   logic [7:0] a_rom_data;
   logic       a_ser_clk, a_ser_data, a_latch, a_busy, a_done;

   logic [7:0] a_mem [16] = '{8'h80, 8'h81, 8'h02, 8'h0B, 8'hFF, 8'h00, 8'hA5, 8'h3C,
                              8'h7E, 8'h01, 8'h40, 8'hC8, 8'h55, 8'hAA, 8'h96, 8'h69};

   always @(posedge clk) a_rom_data <= a_mem[a_rom_addr];

   rom_frame_serializer u_a (
      .clk      (clk),
      .reset    (reset),
      .start    (a_start),
      .rom_addr (a_rom_addr),
      .rom_data (a_rom_data),
      .ser_clk  (a_ser_clk),
      .ser_data (a_ser_data),
      .latch    (a_latch),
      .busy     (a_busy),
      .done     (a_done)
   );

   // ---------------- instance B: fast clock, short frame ----------------
   logic       b_start;
   logic [3:0] b_rom_addr;
   logic [7:0] b_rom_data;
   logic       b_ser_clk, b_ser_data, b_latch, b_busy, b_done;

   logic [7:0] b_mem [4] = '{8'h0B, 8'hC3, 8'h5A, 8'h01};

   always @(posedge clk) b_rom_data <= b_mem[b_rom_addr[1:0]];

   rom_frame_serializer #(.SCLK_DIV(1), .LAST_ADDR(3)) u_b (
      .clk      (clk),
      .reset    (reset),
      .start    (b_start),
      .rom_addr (b_rom_addr),
      .rom_data (b_rom_data),
      .ser_clk  (b_ser_clk),
      .ser_data (b_ser_data),
      .latch    (b_latch),
      .busy     (b_busy),
      .done     (b_done)
   );

   // ---------------- monitors ----------------
   logic       a_sclk_q = 1'b0;
   logic [7:0] a_bits   = 8'h00;
   logic [7:0] a_got [16];
   logic [3:0] a_last_latch_addr = 4'h0;
   int a_latch_n = 0, a_done_n = 0, a_busy_n = 0, a_rise_n = 0;
   int a_since = 1000, a_gap_min = 1000;

   always @(negedge clk) begin
      a_sclk_q <= a_ser_clk;
      if (a_ser_clk && !a_sclk_q) begin
         a_bits   <= {a_bits[6:0], a_ser_data};
         a_rise_n <= a_rise_n + 1;
         if (a_since < a_gap_min) a_gap_min <= a_since;
         a_since  <= 1;
      end else begin
         a_since <= a_since + 1;
      end
      if (a_latch) begin
         a_got[a_rom_addr]  <= a_bits;
         a_latch_n          <= a_latch_n + 1;
         a_last_latch_addr  <= a_rom_addr;
      end
      if (a_done) a_done_n <= a_done_n + 1;
      if (a_busy) a_busy_n <= a_busy_n + 1;
   end

   logic       b_sclk_q = 1'b0;
   logic [7:0] b_bits   = 8'h00;
   logic [7:0] b_got [4];
   int b_latch_n = 0, b_done_n = 0, b_busy_n = 0, b_rise_n = 0;
   int b_since = 1000, b_gap_min = 1000;

   always @(negedge clk) begin
      b_sclk_q <= b_ser_clk;
      if (b_ser_clk && !b_sclk_q) begin
         b_bits   <= {b_bits[6:0], b_ser_data};
         b_rise_n <= b_rise_n + 1;
         if (b_since < b_gap_min) b_gap_min <= b_since;
         b_since  <= 1;
      end else begin
         b_since <= b_since + 1;
      end
      if (b_latch) begin
         b_got[b_rom_addr[1:0]] <= b_bits;
         b_latch_n              <= b_latch_n + 1;
      end
      if (b_done) b_done_n <= b_done_n + 1;
      if (b_busy) b_busy_n <= b_busy_n + 1;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-18s ok    got=%0h", tag, got);
      end else begin
         $display("FAIL %-18s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // The monitor shifts each received bit in from the right, so the first bit
   // sent ends up in bit 7 of the collected byte.
   function automatic logic [7:0] ser_order(input logic [7:0] w);
      logic [7:0] r;
`ifdef SERIALIZER_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[7-i] = w[i];
`else
      r = w;
`endif
      return r;
   endfunction

   task automatic pulse_a();
      @(posedge clk); #1 a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
   endtask

   task automatic pulse_b();
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
   endtask

   task automatic wait_done_a(input int limit, input string tag);
      int k = 0;
      @(negedge clk);
      while (!a_done && k < limit) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, a_done}, 32'd1);
   endtask

   task automatic wait_done_b(input int limit, input string tag);
      int k = 0;
      @(negedge clk);
      while (!b_done && k < limit) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, b_done}, 32'd1);
   endtask

   task automatic wait_a_addr(input logic [3:0] addr, input int limit, input string tag);
      int k = 0;
      @(negedge clk);
      while (!(a_rom_addr == addr && a_ser_clk) && k < limit) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, (a_rom_addr == addr && a_ser_clk)}, 32'd1);
   endtask

   int bl, bd, bb, br;

   initial begin
      reset   = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state_a", {a_rom_addr, a_ser_clk, a_ser_data, a_latch, a_busy, a_done}, 32'd0);
      check("reset_state_b", {b_rom_addr, b_ser_clk, b_ser_data, b_latch, b_busy, b_done}, 32'd0);

      // 1: asynchronous reset while word 3 is shifting.
      pulse_a();
      wait_a_addr(4'd3, 400, "t1_reach_word3");
      #2 reset = 1'b1;
      #1 check("t1_async_clear", {a_rom_addr, a_ser_clk, a_ser_data, a_latch, a_busy, a_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      bl = a_latch_n;
      bd = a_done_n;
      repeat (100) @(negedge clk);
      check("t1_no_latch", a_latch_n - bl, 0);
      check("t1_no_done", a_done_n - bd, 0);
      check("t1_idle_busy", {31'd0, a_busy}, 32'd0);

      // 2 and 6: one full frame with hand-picked words.
      // 0x80 and 0x81 exercise bit order. 0x0B sits at address 3.
      bl = a_latch_n; bd = a_done_n; bb = a_busy_n; br = a_rise_n;
      pulse_a();
      wait_done_a(700, "t2_done_seen");
      check("t2_busy_low_at_done", {31'd0, a_busy}, 32'd0);
      @(negedge clk);
      check("t2_done_1clk", {31'd0, a_done}, 32'd0);
      check("t2_latches", a_latch_n - bl, 16);
      check("t2_dones", a_done_n - bd, 1);
      check("t2_busy_clks", a_busy_n - bb, 560);
      check("t2_rises", a_rise_n - br, 128);
      check("t2_sclk_period", a_gap_min, 4);
      check("t2_addr_wrap", {28'd0, a_rom_addr}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_word%0d", i), {24'd0, a_got[i]}, {24'd0, ser_order(a_mem[i])});
      end
      check("t6_word_0x0b", {24'd0, a_got[3]}, {24'd0, ser_order(8'h0B)});

      // 3: start held high across the frame boundary.
      bl = a_latch_n; bd = a_done_n; bb = a_busy_n;
      @(posedge clk); #1 a_start = 1'b1;
      wait_done_a(700, "t3_first_done");
      check("t3_busy_at_done", {31'd0, a_busy}, 32'd0);
      @(negedge clk);
      check("t3_restart_busy", {31'd0, a_busy}, 32'd1);
      check("t3_done_cleared", {31'd0, a_done}, 32'd0);
      #1 a_start = 1'b0;
      wait_done_a(700, "t3_second_done");
      @(negedge clk);
      check("t3_latches", a_latch_n - bl, 32);
      check("t3_dones", a_done_n - bd, 2);
      check("t3_busy_clks", a_busy_n - bb, 1120);
      check("t3_idle_after", {31'd0, a_busy}, 32'd0);

      // 4: a start pulse while the frame is busy must be ignored.
      bl = a_latch_n; bd = a_done_n; bb = a_busy_n;
      pulse_a();
      wait_a_addr(4'd7, 400, "t4_reach_word7");
      pulse_a();
      wait_done_a(700, "t4_done_seen");
      @(negedge clk);
      check("t4_latches", a_latch_n - bl, 16);
      check("t4_busy_clks", a_busy_n - bb, 560);
      check("t4_last_addr", {28'd0, a_last_latch_addr}, 32'd15);
      repeat (50) @(negedge clk);
      check("t4_single_done", a_done_n - bd, 1);
      check("t4_stays_idle", {31'd0, a_busy}, 32'd0);

      // 5: SCLK_DIV=1, four words per frame.
      bl = b_latch_n; bd = b_done_n; bb = b_busy_n; br = b_rise_n;
      pulse_b();
      wait_done_b(200, "t5_done_seen");
      check("t5_busy_low_at_done", {31'd0, b_busy}, 32'd0);
      @(negedge clk);
      check("t5_latches", b_latch_n - bl, 4);
      check("t5_dones", b_done_n - bd, 1);
      check("t5_busy_clks", b_busy_n - bb, 76);
      check("t5_rises", b_rise_n - br, 32);
      check("t5_sclk_period", b_gap_min, 2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t5_word%0d", i), {24'd0, b_got[i]}, {24'd0, ser_order(b_mem[i])});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
